// File: rtl/reg_bank.sv
// reg_bank: general-purpose register file, 1 write port, 2 combinational read ports, r0 reads as zero.
// Latency: a write lands at the next edge; reads are combinational. A clear sweep takes DEPTH-1 cycles.
// Backpressure: wr_ack drops while busy, while clr_req is high or in reset. Optional bypass: REG_BANK_BYPASS_EN.
module reg_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ack,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_in_range;

  // Register 0 has no storage; index 0 is never referenced.
  logic [WIDTH-1:0]  mem [1:DEPTH-1];

  assign busy        = (state_q == CLEAR);
  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  // Reset, a running sweep and a fresh clear request all block writes.
  assign wr_ack      = rst & wr_en & ~busy & ~clr_req & wr_in_range;

  // Sweep state and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: clr_req starts a sweep only from IDLE; repeats during CLEAR are ignored.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = ADDR_W'(1);
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = ADDR_W'(1);
      end
    endcase
  end

  // Storage update: reset zeroes everything, the sweep zeroes one entry per edge, else accepted writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == CLEAR) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (ptr_q == ADDR_W'(i)) mem[i] <= '0;
      end
    end else if (wr_ack) begin
      // A write to r0 matches no entry and is silently dropped.
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
      end
    end
  end

  // Read muxes: addresses 0 and >= DEPTH match no entry and return zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = mem[i];
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = mem[i];
    end
`ifdef REG_BANK_BYPASS_EN
    // Write-through forwarding; wr_ack is low during a sweep so nothing forwards then.
    if (wr_ack && (wr_addr != '0) && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (wr_ack && (wr_addr != '0) && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
`endif
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank (WIDTH 32, DEPTH 16): reset, write/read, r0, bypass, clear sweep,
// clear/write priority and reset during a sweep. Inputs change 1 time unit after the rising edge
// and outputs are sampled 1 unit later, well clear of the next edge.
module tb_reg_bank;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a, rd_data_b;
  logic              clr_req;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt;

  reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read one address on port a and compare.
  task automatic read_a(input string tag, input int addr, input logic [WIDTH-1:0] exp);
    rd_addr_a = ADDR_W'(addr);
    #1;
    check($sformatf("%s r%0d", tag, addr), rd_data_a, exp);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;

    // ---- reset held for two edges; a write during reset is not acked
    tick();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFF_FFFF;
    #1;
    check("ack_in_reset", {31'b0, wr_ack}, 32'd0);
    tick();
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    check("busy_after_reset", {31'b0, busy}, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = ADDR_W'(a);
      rd_addr_b = ADDR_W'(DEPTH - 1 - a);
      #1;
      check($sformatf("reset_rd_a r%0d", a), rd_data_a, 32'd0);
      check($sformatf("reset_rd_b r%0d", DEPTH - 1 - a), rd_data_b, 32'd0);
    end

    // ---- write r5 and read it back; same-cycle read depends on bypass
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; rd_addr_a = 4'd5;
    #1;
    check("wr_ack_r5", {31'b0, wr_ack}, 32'd1);
`ifdef REG_BANK_BYPASS_EN
    check("same_cycle_r5", rd_data_a, 32'hDEAD_BEEF);
`else
    check("same_cycle_r5", rd_data_a, 32'd0);
`endif
    tick();
    wr_en = 1'b0;
    read_a("after_wr", 5, 32'hDEAD_BEEF);

    // ---- write to r0 is acked but discarded
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0000_1234; rd_addr_a = 4'd0;
    #1;
    check("wr_ack_r0", {31'b0, wr_ack}, 32'd1);
    check("r0_no_bypass", rd_data_a, 32'd0);
    tick();
    wr_en = 1'b0;
    read_a("r0_after_wr", 0, 32'd0);

    // ---- bypass on port b: r7 = 1, then overwrite with A5A5A5A5
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_0001;
    tick();
    wr_data = 32'hA5A5_A5A5; rd_addr_b = 4'd7;
    #1;
`ifdef REG_BANK_BYPASS_EN
    check("bypass_b_r7", rd_data_b, 32'hA5A5_A5A5);
`else
    check("bypass_b_r7", rd_data_b, 32'h0000_0001);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("r7_after_edge", rd_data_b, 32'hA5A5_A5A5);
    read_a("r5_untouched", 5, 32'hDEAD_BEEF);

    // ---- fill r1..r15 with their index
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    read_a("fill", 15, 32'd15);
    read_a("fill", 9, 32'd9);

    // ---- clear sweep with writes held off during busy
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 32'h0000_FFFF;
    #1;
    check("busy_rise", {31'b0, busy}, 32'd1);
    check("ack_while_busy", {31'b0, wr_ack}, 32'd0);
    busy_cnt = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    for (int i = 1; i <= 4; i++) read_a("mid_sweep", i, 32'd0);
    read_a("mid_sweep", 5, 32'd5);
    read_a("mid_sweep", 9, 32'd9);
    read_a("blocked_wr", 10, 32'd10);
    for (int k = 0; k < 40 && busy; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    wr_en = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'd15);
    check("busy_fell", {31'b0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) read_a("after_clear", i, 32'd0);

    // ---- first write right after the sweep is accepted
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_0033;
    #1;
    check("ack_after_clear", {31'b0, wr_ack}, 32'd1);
    tick();
    wr_en = 1'b0;
    read_a("post_clear_wr", 3, 32'h0000_0033);

    // ---- clr_req beats a same-cycle write; a repeat clr_req does not restart
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_0055;
    #1;
    check("ack_vs_clr", {31'b0, wr_ack}, 32'd0);
    tick();
    clr_req = 1'b0; wr_en = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    clr_req = 1'b1;
    tick();
    if (busy) busy_cnt++;
    clr_req = 1'b0;
    for (int k = 0; k < 40 && busy; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("busy_cycles_reclr", 32'(busy_cnt), 32'd15);
    read_a("prio", 3, 32'd0);

    // ---- reset six cycles into a sweep, with a write pending
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'h0000_000C;
    tick();
    wr_addr = 4'd14; wr_data = 32'h0000_000E;
    tick();
    wr_en = 1'b0;
    read_a("pre_rst", 12, 32'h0000_000C);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'h0000_0BAD;
    #1;
    check("ack_in_rst", {31'b0, wr_ack}, 32'd0);
    tick();
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("busy_after_rst", {31'b0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) read_a("after_rst", i, 32'd0);
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'h0000_0077;
    #1;
    check("ack_after_rst", {31'b0, wr_ack}, 32'd1);
    tick();
    wr_en = 1'b0;
    read_a("wr_after_rst", 12, 32'h0000_0077);
    check("still_idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
